// File: rtl/pwm_dac.sv
// pwm_dac: double-buffered PWM DAC output stage.
// A BITS-wide duty code arrives over a valid/ready handshake, waits in a
// one-deep pending buffer, and is loaded into the PWM generator only on a
// period boundary. The output therefore never glitches in the middle of a period.
// Optional feature macro: PWM_SLEW_EN. When it is defined, duty_active ramps
// toward the requested code by at most STEP per period. When it is undefined,
// duty_active jumps straight to the requested code.
//
// Handshake: a transfer happens on every rising clk edge where
// code_valid && code_ready. code_ready is high exactly when the pending buffer
// is empty. Once the upstream raises code_valid, it must hold code_in stable
// until the transfer completes, so no code is ever dropped.
module pwm_dac #(
  parameter int BITS     = 12,
  parameter int PRESCALE = 1,
  parameter int STEP     = 256
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [BITS-1:0] code_in,
  input  logic            code_valid,
  output logic            code_ready,
  output logic            pwm_out,
  output logic            period_start,
  output logic [BITS-1:0] duty_active
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]   PRE_MAX = PW'(PRESCALE - 1);
  // The last count value in a period is 2^BITS-2, so a period is 2^BITS-1 ticks long.
  localparam logic [BITS-1:0] CNT_MAX = {{(BITS-1){1'b1}}, 1'b0};

  // Stop elaboration if the parameters are outside their meaningful range.
  generate
    if (PRESCALE < 1 || STEP < 1 || STEP > (2**BITS) - 1) begin : g_bad_param
      $error("pwm_dac: PRESCALE must be >= 1 and STEP must be in 1..2^BITS-1");
    end
  endgenerate

  logic [PW-1:0]   pre_q, pre_d;
  logic [BITS-1:0] cnt_q, cnt_d;
  logic [BITS-1:0] pend_q, pend_d;
  logic            pend_full_q, pend_full_d;
  logic [BITS-1:0] target_q, target_d;
  logic [BITS-1:0] duty_q, duty_d;
  logic            pwm_q, pwm_d;
  logic            ps_q, ps_d;
  logic            tick;
  logic            boundary;
  logic            accept;

  // Prescaler and period counter. A boundary is the last tick of a period.
  always_comb begin
    tick     = (pre_q == PRE_MAX);
    boundary = tick && (cnt_q == CNT_MAX);
    pre_d    = tick ? '0 : pre_q + 1'b1;
    cnt_d    = cnt_q;
    if (tick) begin
      cnt_d = (cnt_q == CNT_MAX) ? '0 : cnt_q + 1'b1;
    end
  end

  // Pending buffer and target. A code accepted during the boundary cycle
  // cannot be drained in that same cycle, because the buffer was empty then.
  // That code therefore waits for the next boundary.
  always_comb begin
    accept      = code_valid && !pend_full_q;
    pend_d      = pend_q;
    pend_full_d = pend_full_q;
    target_d    = target_q;
    if (boundary && pend_full_q) begin
      target_d    = pend_q;
      pend_full_d = 1'b0;
    end
    if (accept) begin
      pend_d      = code_in;
      pend_full_d = 1'b1;
    end
  end

`ifdef PWM_SLEW_EN
  localparam logic [BITS:0]   STEP_W = (BITS+1)'(STEP);
  localparam logic [BITS-1:0] STEP_N = BITS'(STEP);
  logic [BITS:0] tgt_w, dty_w, up_w, dn_lim_w;

  // At each boundary, move duty toward the freshly updated target by at most
  // STEP. The math is one bit wider so it cannot overflow or underflow.
  always_comb begin
    tgt_w    = {1'b0, target_d};
    dty_w    = {1'b0, duty_q};
    up_w     = dty_w + STEP_W;
    dn_lim_w = tgt_w + STEP_W;
    duty_d   = duty_q;
    if (boundary) begin
      if (tgt_w > dty_w) begin
        duty_d = (up_w >= tgt_w) ? target_d : up_w[BITS-1:0];
      end else if (dty_w > tgt_w) begin
        duty_d = (dty_w <= dn_lim_w) ? target_d : duty_q - STEP_N;
      end
    end
  end
`else
  // At each boundary, duty jumps directly to the freshly updated target.
  always_comb begin
    duty_d = duty_q;
    if (boundary) begin
      duty_d = target_d;
    end
  end
`endif

  // Next values for the registered PWM compare and the period-start pulse.
  always_comb begin
    pwm_d = (cnt_q < duty_q);
    ps_d  = boundary;
  end

  // State registers. Reset clears everything, including any pending code.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q       <= '0;
      cnt_q       <= '0;
      pend_q      <= '0;
      pend_full_q <= 1'b0;
      target_q    <= '0;
      duty_q      <= '0;
      pwm_q       <= 1'b0;
      ps_q        <= 1'b0;
    end else begin
      pre_q       <= pre_d;
      cnt_q       <= cnt_d;
      pend_q      <= pend_d;
      pend_full_q <= pend_full_d;
      target_q    <= target_d;
      duty_q      <= duty_d;
      pwm_q       <= pwm_d;
      ps_q        <= ps_d;
    end
  end

  assign code_ready   = !pend_full_q;
  assign pwm_out      = pwm_q;
  assign period_start = ps_q;
  assign duty_active  = duty_q;

endmodule

// File: tb/tb_pwm_dac.sv
// tb_pwm_dac: self-checking bench for pwm_dac with BITS=12, PRESCALE=1, STEP=256.
// The default build covers reset, a duty table, back-to-back codes and a
// mid-period reset. A build with PWM_SLEW_EN defined covers the slew ramp.
module tb_pwm_dac;

  localparam int BITS   = 12;
  localparam int PERIOD = 4095;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [BITS-1:0] code_in = '0;
  logic            code_valid = 1'b0;
  logic            code_ready;
  logic            pwm_out;
  logic            period_start;
  logic [BITS-1:0] duty_active;

  pwm_dac #(.BITS(BITS), .PRESCALE(1), .STEP(256)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .code_in      (code_in),
    .code_valid   (code_valid),
    .code_ready   (code_ready),
    .pwm_out      (pwm_out),
    .period_start (period_start),
    .duty_active  (duty_active)
  );

  // clock / reset
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // scoreboard: duty values expected to appear on duty_active, in order
  logic [BITS-1:0] exp_q[$];

  int              cyc = 0;
  int              ps_count = 0;
  int              hi_cnt = 0;
  int              last_hi = 0;
  int              last_gap = 0;
  int              last_ps_cyc = 0;
  logic [BITS-1:0] prev_duty = '0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s timed out", name);
  endtask

  // monitor: high-count per period window, period spacing, duty scoreboard
  always @(negedge clk) begin
    logic [BITS-1:0] e;
    cyc++;
    if (!rst_n) begin
      hi_cnt      = 0;
      last_ps_cyc = cyc + 1;
      prev_duty   = duty_active;
    end else begin
      hi_cnt += int'(pwm_out);
      if (period_start) begin
        last_hi     = hi_cnt;
        last_gap    = cyc - last_ps_cyc;
        last_ps_cyc = cyc;
        hi_cnt      = 0;
        ps_count++;
      end
      if (duty_active != prev_duty) begin
        check("duty_change_on_period_start", int'(period_start), 1);
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL duty_unexpected actual=%0d expected=no change", duty_active);
        end else begin
          e = exp_q.pop_front();
          check("duty_scoreboard", int'(duty_active), int'(e));
        end
        prev_duty = duty_active;
      end
    end
  end

  // driver: present a code and hold it until the handshake completes
  task automatic send_code(input logic [BITS-1:0] c, output int stall, output logic ps_seen);
    stall = 0;
    @(negedge clk);
    code_in    = c;
    code_valid = 1'b1;
    while (!code_ready && stall < 2 * PERIOD) begin
      @(negedge clk);
      stall++;
    end
    ps_seen = period_start;
    if (!code_ready) begin
      fail_now("send_code");
      code_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1 code_valid = 1'b0;
    end
  endtask

  // wait for the monitor to see the next period_start
  task automatic wait_ps();
    int  start;
    logic ok;
    start = ps_count;
    ok = 1'b0;
    for (int i = 0; i < PERIOD + 100; i++) begin
      @(posedge clk);
      if (ps_count != start) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) fail_now("wait_period_start");
  endtask

  typedef struct {
    logic [BITS-1:0] code;
    int              exp_hi;
    int              n_per;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int   stall;
    logic ps_seen;

    vecs[0] = '{code: 12'd2048, exp_hi: 2048, n_per: 2};
    vecs[1] = '{code: 12'd0,    exp_hi: 0,    n_per: 1};
    vecs[2] = '{code: 12'd4095, exp_hi: 4095, n_per: 3};
    vecs[3] = '{code: 12'd1,    exp_hi: 1,    n_per: 1};

    // reset with code_valid asserted: nothing may be accepted
    rst_n      = 1'b0;
    code_in    = 12'd1234;
    code_valid = 1'b1;
    repeat (5) @(negedge clk);
    check("rst_pwm_out", int'(pwm_out), 0);
    check("rst_duty_active", int'(duty_active), 0);
    check("rst_period_start", int'(period_start), 0);
    check("rst_code_ready", int'(code_ready), 1);
    code_valid = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_code_ready", int'(code_ready), 1);

`ifdef PWM_SLEW_EN
    // ramp 0 -> 4095 in steps of 256, finishing with a partial step
    send_code(12'd4095, stall, ps_seen);
    for (int k = 1; k <= 15; k++) exp_q.push_back(BITS'(k * 256));
    exp_q.push_back(12'd4095);
    for (int i = 0; i < 16; i++) wait_ps();
    @(negedge clk);
    check("slew_final", int'(duty_active), 4095);
    // a change smaller than STEP lands in a single step
    send_code(12'd4000, stall, ps_seen);
    exp_q.push_back(12'd4000);
    wait_ps();
    @(negedge clk);
    check("slew_small_step", int'(duty_active), 4000);
`else
    // table: each code's high count per period and the period spacing
    for (int v = 0; v < 4; v++) begin
      send_code(vecs[v].code, stall, ps_seen);
      exp_q.push_back(vecs[v].code);
      for (int a = 0; a < 2; a++) begin
        wait_ps();
        @(negedge clk);
        if (duty_active == vecs[v].code) break;
      end
      check("vec_duty_active", int'(duty_active), int'(vecs[v].code));
      for (int p = 0; p < vecs[v].n_per; p++) begin
        wait_ps();
        check($sformatf("vec%0d_high_count", v), last_hi, vecs[v].exp_hi);
        check($sformatf("vec%0d_period_gap", v), last_gap, PERIOD);
      end
    end

    // back-to-back codes: the second one stalls until the boundary drains the buffer
    send_code(12'd100, stall, ps_seen);
    exp_q.push_back(12'd100);
    @(negedge clk);
    check("b2b_ready_drop", int'(code_ready), 0);
    send_code(12'd3000, stall, ps_seen);
    exp_q.push_back(12'd3000);
    check("b2b_stalled", int'(stall > 0), 1);
    check("b2b_ready_on_period_start", int'(ps_seen), 1);
    wait_ps();
    check("b2b_first_high_count", last_hi, 100);
    @(negedge clk);
    check("b2b_second_active", int'(duty_active), 3000);
    wait_ps();
    check("b2b_second_high_count", last_hi, 3000);

    // reset mid-period while a code is pending
    send_code(12'd500, stall, ps_seen);
    exp_q.push_back(12'd500);
    repeat (100) @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_pwm_out", int'(pwm_out), 0);
    check("mid_rst_duty_active", int'(duty_active), 0);
    check("mid_rst_period_start", int'(period_start), 0);
    check("mid_rst_code_ready", int'(code_ready), 1);
    exp_q.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    wait_ps();
    check("first_ps_after_reset", last_gap, PERIOD);
    @(negedge clk);
    check("pending_discarded", int'(duty_active), 0);
    wait_ps();
    check("pending_discarded_high_count", last_hi, 0);
`endif

    check("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // watchdog
  initial begin
    #1500000;
    failures++;
    $display("FAIL watchdog simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
